// File: rtl/demultiplexer.sv
// Registered 1-to-4 demultiplexer: on every clock edge, A is routed to the
// destination chosen by SEL. VLD is a one-hot flag marking which destination
// was loaded. Unselected destinations are either cleared or left holding
// their last value, depending on HOLD.
module demultiplexer #(
  parameter int DATA_W = 2,
  parameter int HOLD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [1:0]        SEL,
  output logic [DATA_W-1:0] W,
  output logic [DATA_W-1:0] X,
  output logic [DATA_W-1:0] Y,
  output logic [DATA_W-1:0] Z,
  output logic [3:0]        VLD
);

  localparam int NUM_DST = 4;

  logic [NUM_DST-1:0][DATA_W-1:0] dst_q, dst_d;
  logic [NUM_DST-1:0]             vld_q, vld_d;

  // Next state: the selected slot takes A; the others are cleared or kept.
  always_comb begin
    dst_d      = (HOLD != 0) ? dst_q : '0;
    dst_d[SEL] = A;
    vld_d      = 4'b0001 << SEL;
  end

  // Output registers; reset clears everything at once, whatever HOLD is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_q <= '0;
      vld_q <= '0;
    end else begin
      dst_q <= dst_d;
      vld_q <= vld_d;
    end
  end

  assign W   = dst_q[0];
  assign X   = dst_q[1];
  assign Y   = dst_q[2];
  assign Z   = dst_q[3];
  assign VLD = vld_q;

endmodule

// File: tb/tb_demultiplexer.sv
// Bench for demultiplexer: three instances share clk/rst/SEL --
//   u0: DATA_W=2 HOLD=0, u1: DATA_W=2 HOLD=1, u2: DATA_W=8 HOLD=0.
// Directed vectors push hand-computed expectations into a queue; a monitor
// pops and compares on the falling edge whenever u0 presents a valid output.
module tb_demultiplexer;

  typedef struct packed {
    logic [7:0]  e0;   // u0 {W,X,Y,Z}
    logic [7:0]  e1;   // u1 {W,X,Y,Z}
    logic [31:0] e2;   // u2 {W,X,Y,Z}
    logic [3:0]  vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = '0;
  logic [1:0] a2  = '0;
  logic [7:0] a8  = '0;

  logic [1:0] w0, x0, y0, z0, w1, x1, y1, z1;
  logic [7:0] w2, x2, y2, z2;
  logic [3:0] vld0, vld1, vld2;

  exp_t q[$];
  bit   mon_en = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  demultiplexer #(.DATA_W(2), .HOLD(0)) u0 (
    .clk(clk), .rst(rst), .A(a2), .SEL(sel),
    .W(w0), .X(x0), .Y(y0), .Z(z0), .VLD(vld0));
  demultiplexer #(.DATA_W(2), .HOLD(1)) u1 (
    .clk(clk), .rst(rst), .A(a2), .SEL(sel),
    .W(w1), .X(x1), .Y(y1), .Z(z1), .VLD(vld1));
  demultiplexer #(.DATA_W(8), .HOLD(0)) u2 (
    .clk(clk), .rst(rst), .A(a8), .SEL(sel),
    .W(w2), .X(x2), .Y(y2), .Z(z2), .VLD(vld2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " u0"},   {24'h0, w0, x0, y0, z0}, {24'h0, e.e0});
    chk({tag, " u1"},   {24'h0, w1, x1, y1, z1}, {24'h0, e.e1});
    chk({tag, " u2"},   {w2, x2, y2, z2},        e.e2);
    chk({tag, " vld0"}, {28'h0, vld0},           {28'h0, e.vld});
    chk({tag, " vld1"}, {28'h0, vld1},           {28'h0, e.vld});
    chk({tag, " vld2"}, {28'h0, vld2},           {28'h0, e.vld});
  endtask

  // Monitor: one expectation consumed per valid output cycle.
  always @(negedge clk) begin
    if (mon_en && vld0 != 4'b0000) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: vld0=%b with empty queue", vld0);
      end else begin
        chk_all("scoreboard", q.pop_front());
      end
    end
  end

  // Drive one vector, then queue its expectation once the edge has sampled it.
  task automatic apply(input logic [1:0] s, input logic [1:0] a, input logic [7:0] b,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [31:0] e2, input logic [3:0] v);
    exp_t e;
    sel = s; a2 = a; a8 = b;
    @(posedge clk);
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.vld = v;
    q.push_back(e);
    #2;
  endtask

  task automatic mon_off();
    @(negedge clk); #1;
    mon_en = 1'b0;
  endtask

  localparam exp_t ZERO = '0;

  initial begin
    // Reset state, checked while rst is held high.
    #12;
    chk_all("reset", ZERO);
    @(negedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Sweep: SEL 0..3 on consecutive edges.
    apply(2'd0, 2'b01, 8'h11, 8'b01_00_00_00, 8'b01_00_00_00, 32'h11_00_00_00, 4'b0001);
    apply(2'd1, 2'b11, 8'h22, 8'b00_11_00_00, 8'b01_11_00_00, 32'h00_22_00_00, 4'b0010);
    apply(2'd2, 2'b10, 8'h33, 8'b00_00_10_00, 8'b01_11_10_00, 32'h00_00_33_00, 4'b0100);
    apply(2'd3, 2'b01, 8'hA5, 8'b00_00_00_01, 8'b01_11_10_01, 32'h00_00_00_A5, 4'b1000);
    mon_off();

    // Latency: mid-cycle input change must not reach the outputs before the edge.
    sel = 2'd0; a2 = 2'b11; a8 = 8'h77;
    #3;
    chk("latency_hold u0", {24'h0, w0, x0, y0, z0, vld0}, {24'h0, 8'b00_00_00_01, 4'b1000});
    chk("latency_hold u2", {w2, x2, y2, z2}, 32'h00_00_00_A5);
    @(posedge clk); #1;
    chk("latency_load u0", {20'h0, w0, x0, y0, z0, vld0}, {20'h0, 8'b11_00_00_00, 4'b0001});

    // Clear state before the hold scenario.
    #2 rst = 1'b1;
    #1 chk_all("reset_pulse", ZERO);
    @(negedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Hold policy, zero data, then Z=10 ready for the async reset check.
    apply(2'd0, 2'b11, 8'hFF, 8'b11_00_00_00, 8'b11_00_00_00, 32'hFF_00_00_00, 4'b0001);
    apply(2'd2, 2'b01, 8'h00, 8'b00_00_01_00, 8'b11_00_01_00, 32'h00_00_00_00, 4'b0100);
    apply(2'd1, 2'b00, 8'h80, 8'b00_00_00_00, 8'b11_00_01_00, 32'h00_80_00_00, 4'b0010);
    apply(2'd3, 2'b10, 8'h01, 8'b00_00_00_10, 8'b11_00_01_10, 32'h00_00_00_01, 4'b1000);
    mon_off();

    // Async reset between edges, and outputs stay cleared across an edge.
    chk("pre_reset z0", {30'h0, z0}, 32'h2);
    rst = 1'b1;
    #1 chk_all("async_reset", ZERO);
    @(posedge clk); #1;
    chk_all("reset_held", ZERO);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    // First edge after reset resumes normal loading; held values were cleared.
    apply(2'd1, 2'b10, 8'h5A, 8'b00_10_00_00, 8'b00_10_00_00, 32'h00_5A_00_00, 4'b0010);
    mon_off();
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
